rob_ctrl: RTL
=============

# rob_ctrl

Reorder-buffer control block that sits beside the front-end RAT. It allocates in-order ROB IDs to up to two renamed instructions per cycle and supplies the allocation pointers and full flag to the FRAT. It collects completion from the writeback buses, retires up to two oldest completed entries per cycle on the registered retire bus the FRAT consumes, and optionally recovers from branch mispredicts.

## Interface

Parameters:
- ISSUE_WIDTH_MAX, 2, instructions allocated per cycle (block is specified for 2)
- ROB_MAX_RETIRE, 2, retire lanes (specified for 2)
- ROB_SIZE, 32, entries; power of two
- ROB_SIZE_CLOG, 5, log2(ROB_SIZE)
- SRC_LEN, 5, architectural register index width
- OPCODE_LEN, 7, opcode width
- CDB_WIDTH, 2, writeback/completion buses

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- instr_val_id  in  ISSUE_WIDTH_MAX  valid instruction per issue lane
- opcode_id  in  ISSUE_WIDTH_MAX x OPCODE_LEN  opcode per issue lane
- rd_id  in  ISSUE_WIDTH_MAX x SRC_LEN  destination register per issue lane
- cdb_val  in  CDB_WIDTH  completion valid
- cdb_robid  in  CDB_WIDTH x ROB_SIZE_CLOG  completing ROB ID
- mispredict_val  in  1  branch mispredict resolved this cycle
- mispredict_robid  in  ROB_SIZE_CLOG  ROB ID of the mispredicted branch
- rob_is_ptr  out  ROB_SIZE_CLOG  tail (next allocation ID)
- rob_is_ptr_p1  out  ROB_SIZE_CLOG  tail+1 mod ROB_SIZE
- rob_full  out  1  fewer than ISSUE_WIDTH_MAX free entries
- rd_ret  out  ROB_MAX_RETIRE x SRC_LEN  retiring destination register
- val_ret  out  ROB_MAX_RETIRE  retire lane valid
- branch_ret  out  ROB_MAX_RETIRE  retiring instruction writes no rd (SB_TYPE or S_TYPE)
- robid_ret  out  ROB_MAX_RETIRE x ROB_SIZE_CLOG  retiring ROB ID
- branch_clear_id  out  1  registered flush pulse
- mispredict_tag_id  out  ROB_SIZE_CLOG  registered mispredict ROB ID

## Operation

- State: head, tail (ROB_SIZE_CLOG bits, wrapping modulo ROB_SIZE), count (ROB_SIZE_CLOG+1 bits). Per entry: valid, done, rd, nord.
- rob_full = count > ROB_SIZE-ISSUE_WIDTH_MAX. It is decoded from registered count.
- Allocation occurs only when rob_full=0 and no flush is active.
  - Lane 0, if valid, takes ID tail.
  - Lane 1, if valid, takes tail+1 when lane 0 is valid, otherwise tail.
  - Each allocated entry is written with valid=1, done=0, rd=rd_id, nord=(opcode==SB_TYPE or S_TYPE).
  - tail advances by popcount(instr_val_id).
- When rob_full=1, instr_val_id is ignored and no state changes.
- Completion: each cdb_val[w] sets done for cdb_robid[w] if that entry is valid. Completion for an invalid entry is ignored.
- Retire:
  - Lane 0 retires head if it is valid&done.
  - Lane 1 retires head+1 only if lane 0 retires and head+1 is valid&done.
  - Retired entries are cleared, and head advances by the number retired.
  - Completion that arrives in the same cycle is not visible to retire until the next cycle.
- Retire outputs are registered with the fields val_ret, robid_ret, rd_ret, branch_ret (=nord).
  - rd_ret=0 when nord=1.
  - Lanes that do not retire drive val_ret=0; their other fields hold their previous value.
- count_next = count + allocated − retired.

## Timing

- Reset value of every output, and of internal state:
  - head=tail=count=0, all entry valid=0, done=0.
  - rob_full=0, rob_is_ptr=0, rob_is_ptr_p1=1.
  - val_ret=0, branch_ret=0, rd_ret=0, robid_ret=0.
  - branch_clear_id=0, mispredict_tag_id=0.
- rst applied mid-operation discards all entries in the same edge.
- Allocation is visible on rob_is_ptr at the next cycle.
- Latency, minimum path from allocation to val_ret=1:
  - allocate at cycle N;
  - cdb at cycle N+1;
  - retire decision at cycle N+2;
  - val_ret high in cycle N+3.
- Wrap-around: IDs ROB_SIZE-1 → 0 are contiguous. At tail=ROB_SIZE-1, rob_is_ptr_p1=0.
- count==ROB_SIZE is reachable only transiently and cannot be exceeded, because rob_full blocks allocation first.

## Configuration

- ROB_BRANCH_FLUSH_EN defined, on the cycle mispredict_val=1:
  - entries strictly younger than mispredict_robid are invalidated;
  - tail = mispredict_robid+1;
  - count = ((mispredict_robid − head) mod ROB_SIZE) + 1 − retired_this_cycle;
  - allocation that cycle is dropped;
  - retire and completion of entries at or older than the tag proceed normally;
  - branch_clear_id pulses 1 cycle later, with mispredict_tag_id registered at the same edge.
- ROB_BRANCH_FLUSH_EN undefined:
  - mispredict_val and mispredict_robid are ignored;
  - branch_clear_id and mispredict_tag_id are tied to 0.

## Test plan

- Reset, then allocate 2 with rd=3 and rd=4 → IDs 0 and 1, rob_is_ptr=2. Complete ID 1, then ID 0 → next cycle val_ret=2'b11, robid_ret={1,0}, rd_ret={4,3}.
- Allocate lane 1 only (instr_val_id=2'b10) at tail=5 → entry 5 is allocated, tail=6. Its SB_TYPE opcode retires with branch_ret=1 and rd_ret=0.
- Allocate 15 pairs plus 1 single to reach count=31 → rob_full=1. Further instr_val_id=2'b11 is ignored. Retiring 1 entry → rob_full=0.
- Drive head=tail=30 and allocate 2+2 → IDs 30, 31, 0, 1. Retire all 4 in order, with robid_ret wrapping 31→0.
- Complete ID 1 but not ID 0 → val_ret stays 0. Completion to an unallocated ID 9 has no effect.
- With ROB_BRANCH_FLUSH_EN, entries 0–7 live, mispredict_robid=3 together with an allocation → tail=4, allocation dropped, entries 4–7 invalid. branch_clear_id=1 with tag 3 the next cycle.

Source files
------------

// File: rtl/rob_ctrl_if.sv
// rob_ctrl_if: bundles the rename/allocate, writeback, mispredict and retire
// signals of rob_ctrl.
//   master : front-end / writeback / branch unit side (drives allocation,
//            completion and mispredict; observes pointers and retire bus)
//   slave  : rob_ctrl side
interface rob_ctrl_if #(
    parameter int ISSUE_WIDTH_MAX = 2,
    parameter int ROB_MAX_RETIRE  = 2,
    parameter int ROB_SIZE_CLOG   = 5,
    parameter int SRC_LEN         = 5,
    parameter int OPCODE_LEN      = 7,
    parameter int CDB_WIDTH       = 2
);
    logic [ISSUE_WIDTH_MAX-1:0]                 instr_val_id;
    logic [ISSUE_WIDTH_MAX-1:0][OPCODE_LEN-1:0] opcode_id;
    logic [ISSUE_WIDTH_MAX-1:0][SRC_LEN-1:0]    rd_id;
    logic [CDB_WIDTH-1:0]                       cdb_val;
    logic [CDB_WIDTH-1:0][ROB_SIZE_CLOG-1:0]    cdb_robid;
    logic                                       mispredict_val;
    logic [ROB_SIZE_CLOG-1:0]                   mispredict_robid;
    logic [ROB_SIZE_CLOG-1:0]                   rob_is_ptr;
    logic [ROB_SIZE_CLOG-1:0]                   rob_is_ptr_p1;
    logic                                       rob_full;
    logic [ROB_MAX_RETIRE-1:0][SRC_LEN-1:0]     rd_ret;
    logic [ROB_MAX_RETIRE-1:0]                  val_ret;
    logic [ROB_MAX_RETIRE-1:0]                  branch_ret;
    logic [ROB_MAX_RETIRE-1:0][ROB_SIZE_CLOG-1:0] robid_ret;
    logic                                       branch_clear_id;
    logic [ROB_SIZE_CLOG-1:0]                   mispredict_tag_id;

    modport master (
        output instr_val_id, opcode_id, rd_id, cdb_val, cdb_robid,
               mispredict_val, mispredict_robid,
        input  rob_is_ptr, rob_is_ptr_p1, rob_full, rd_ret, val_ret,
               branch_ret, robid_ret, branch_clear_id, mispredict_tag_id
    );

    modport slave (
        input  instr_val_id, opcode_id, rd_id, cdb_val, cdb_robid,
               mispredict_val, mispredict_robid,
        output rob_is_ptr, rob_is_ptr_p1, rob_full, rd_ret, val_ret,
               branch_ret, robid_ret, branch_clear_id, mispredict_tag_id
    );
endinterface

// File: rtl/rob_ctrl.sv
// rob_ctrl: reorder-buffer control. Allocates up to two in-order ROB IDs per
// cycle, marks entries done from the writeback buses, and retires up to two
// oldest done entries per cycle on a registered retire bus.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : rob_ctrl_if.slave (allocation inputs, cdb completion,
//               mispredict, pointers/full flag, retire bus, flush pulse)
// Optional feature: define ROB_BRANCH_FLUSH_EN to enable mispredict recovery
// (younger entries squashed, tail rewound, registered flush pulse). Without
// it the mispredict inputs are ignored and the flush outputs are tied to 0.
module rob_ctrl #(
    parameter int ISSUE_WIDTH_MAX = 2,
    parameter int ROB_MAX_RETIRE  = 2,
    parameter int ROB_SIZE        = 32,
    parameter int ROB_SIZE_CLOG   = 5,
    parameter int SRC_LEN         = 5,
    parameter int OPCODE_LEN      = 7,
    parameter int CDB_WIDTH       = 2
) (
    input  logic        clk,
    input  logic        rst,
    rob_ctrl_if.slave   bus
);
    localparam int CW = ROB_SIZE_CLOG + 1;
    typedef logic [ROB_SIZE_CLOG-1:0] id_t;

    localparam logic [OPCODE_LEN-1:0] SB_TYPE = OPCODE_LEN'(7'b1100011);
    localparam logic [OPCODE_LEN-1:0] S_TYPE  = OPCODE_LEN'(7'b0100011);

    function automatic logic writes_no_rd(input logic [OPCODE_LEN-1:0] op);
        return (op == SB_TYPE) || (op == S_TYPE);
    endfunction

    id_t                 head, tail, head_p1, tail_nxt, id0, id1, tag_off;
    logic [CW-1:0]       count, count_nxt, n_alloc, n_ret;
    logic [ROB_SIZE-1:0] ent_val, ent_done, ent_nord, val_nxt, done_nxt, kill;
    logic [SRC_LEN-1:0]  ent_rd [ROB_SIZE];
    logic                full, flush, alloc0, alloc1, ret0, ret1;
    logic [ROB_MAX_RETIRE-1:0] ret_p0;

    assign full              = count > CW'(ROB_SIZE - ISSUE_WIDTH_MAX);
    assign head_p1           = head + id_t'(1);
    assign bus.rob_full      = full;
    assign bus.rob_is_ptr    = tail;
    assign bus.rob_is_ptr_p1 = tail + id_t'(1);

`ifdef ROB_BRANCH_FLUSH_EN
    assign flush   = bus.mispredict_val;
    assign tag_off = bus.mispredict_robid - head;

    // Ages are measured as distance from head; anything farther than the
    // mispredicted branch is younger and gets squashed.
    always_comb begin
        kill = '0;
        for (int i = 0; i < ROB_SIZE; i++) begin
            kill[i] = (id_t'(i) - head) > tag_off;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.branch_clear_id   <= 1'b0;
            bus.mispredict_tag_id <= '0;
        end else begin
            bus.branch_clear_id <= bus.mispredict_val;
            if (bus.mispredict_val) begin
                bus.mispredict_tag_id <= bus.mispredict_robid;
            end
        end
    end
`else
    logic unused_mispredict;
    assign unused_mispredict     = ^{bus.mispredict_val, bus.mispredict_robid};
    assign flush                 = 1'b0;
    assign tag_off               = '0;
    assign kill                  = '0;
    assign bus.branch_clear_id   = 1'b0;
    assign bus.mispredict_tag_id = '0;
`endif

    // Next-state of the entry flags. Retire looks only at registered done
    // bits, so a completion landing this cycle is seen next cycle.
    always_comb begin
        alloc0   = !full && !flush && bus.instr_val_id[0];
        alloc1   = !full && !flush && bus.instr_val_id[1];
        id0      = tail;
        id1      = bus.instr_val_id[0] ? tail + id_t'(1) : tail;
        ret0     = ent_val[head] && ent_done[head];
        ret1     = ret0 && ent_val[head_p1] && ent_done[head_p1];
        ret_p0   = {ret1, ret0};
        n_alloc  = CW'(alloc0) + CW'(alloc1);
        n_ret    = CW'(ret0) + CW'(ret1);
        val_nxt  = ent_val;
        done_nxt = ent_done;
        for (int w = 0; w < CDB_WIDTH; w++) begin
            if (bus.cdb_val[w] && ent_val[bus.cdb_robid[w]]) begin
                done_nxt[bus.cdb_robid[w]] = 1'b1;
            end
        end
        if (ret0) begin
            val_nxt[head]  = 1'b0;
            done_nxt[head] = 1'b0;
        end
        if (ret1) begin
            val_nxt[head_p1]  = 1'b0;
            done_nxt[head_p1] = 1'b0;
        end
        if (alloc0) begin
            val_nxt[id0]  = 1'b1;
            done_nxt[id0] = 1'b0;
        end
        if (alloc1) begin
            val_nxt[id1]  = 1'b1;
            done_nxt[id1] = 1'b0;
        end
        tail_nxt  = tail + id_t'(n_alloc);
        count_nxt = count + n_alloc - n_ret;
        if (flush) begin
            val_nxt   = val_nxt & ~kill;
            done_nxt  = done_nxt & ~kill;
            tail_nxt  = bus.mispredict_robid + id_t'(1);
            count_nxt = CW'(tag_off) + CW'(1) - n_ret;
        end
    end

    // Stage p0 -> registered retire bus and pointer state
    always_ff @(posedge clk) begin
        if (rst) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            ent_val        <= '0;
            ent_done       <= '0;
            bus.val_ret    <= '0;
            bus.branch_ret <= '0;
            bus.rd_ret     <= '0;
            bus.robid_ret  <= '0;
        end else begin
            head        <= head + id_t'(n_ret);
            tail        <= tail_nxt;
            count       <= count_nxt;
            ent_val     <= val_nxt;
            ent_done    <= done_nxt;
            bus.val_ret <= ret_p0;
            if (ret0) begin
                bus.robid_ret[0]  <= head;
                bus.rd_ret[0]     <= ent_nord[head] ? '0 : ent_rd[head];
                bus.branch_ret[0] <= ent_nord[head];
            end
            if (ret1) begin
                bus.robid_ret[1]  <= head_p1;
                bus.rd_ret[1]     <= ent_nord[head_p1] ? '0 : ent_rd[head_p1];
                bus.branch_ret[1] <= ent_nord[head_p1];
            end
        end
    end

    // Payload storage; only meaningful while the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (alloc0) begin
            ent_rd[id0]   <= bus.rd_id[0];
            ent_nord[id0] <= writes_no_rd(bus.opcode_id[0]);
        end
        if (alloc1) begin
            ent_rd[id1]   <= bus.rd_id[1];
            ent_nord[id1] <= writes_no_rd(bus.opcode_id[1]);
        end
    end
endmodule
